// File: rtl/matrix_pe_acc.sv
// Vector dot-product engine: N paired neuron/weight beats -> multiply -> reduce -> accumulate -> one result.
// Optional clamp of the result to OUT_W range when MPE_SAT_EN is defined; default truncates.
module matrix_pe_acc #(
  parameter int VEC_W  = 512,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48,
  parameter int OUT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ib_ctl_uop,
  input  logic              ib_ctl_uop_valid,
  output logic              ib_ctl_uop_ready,
  input  logic [VEC_W-1:0]  nram_mpe_neuron,
  input  logic              nram_mpe_neuron_valid,
  output logic              nram_mpe_neuron_ready,
  input  logic [VEC_W-1:0]  wram_mpe_weight,
  input  logic              wram_mpe_weight_valid,
  output logic              wram_mpe_weight_ready,
  output logic [OUT_W-1:0]  result,
  output logic              vld_o,
  input  logic              res_ready,
  output logic              busy
);

  localparam int LANES  = VEC_W / DATA_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic [7:0]               n_q, n_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [OUT_W-1:0]         result_q, result_d;
  logic                     s1_vld_q, s2_vld_q;
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [SUM_W-1:0]  sum_d, sum_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [OUT_W-1:0]  acc_res;

  logic beat_fire, uop_fire;

  assign uop_fire  = (state_q == S_IDLE) && ib_ctl_uop_valid;
  // The pair is consumed atomically: one side is never taken without the other.
  assign beat_fire = (state_q == S_ACCUM) && nram_mpe_neuron_valid && wram_mpe_weight_valid;

  assign ib_ctl_uop_ready      = (state_q == S_IDLE);
  assign nram_mpe_neuron_ready = beat_fire;
  assign wram_mpe_weight_ready = beat_fire;
  assign vld_o                 = (state_q == S_OUT);
  assign busy                  = (state_q != S_IDLE);
  assign result                = result_q;

`ifdef MPE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  always_comb begin
    if (acc_q > SAT_MAX)      acc_res = SAT_MAX[OUT_W-1:0];
    else if (acc_q < SAT_MIN) acc_res = SAT_MIN[OUT_W-1:0];
    else                      acc_res = acc_q[OUT_W-1:0];
  end
`else
  assign acc_res = acc_q[OUT_W-1:0];
`endif

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (ib_ctl_uop_valid) begin
          n_d   = ib_ctl_uop;
          cnt_d = '0;
          if (ib_ctl_uop == 8'd0) begin
            state_d  = S_OUT;
            result_d = '0;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (beat_fire) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == n_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Both stage valids low means the last beat has already landed in acc_q.
        if (!s1_vld_q && !s2_vld_q) begin
          state_d  = S_OUT;
          result_d = acc_res;
        end
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      s1_vld_q <= beat_fire;
      s2_vld_q <= s1_vld_q;
      if (uop_fire)
        acc_q <= '0;
      else if (s2_vld_q)
        acc_q <= acc_q + {{(ACC_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_d[l] = $signed(nram_mpe_neuron[l*DATA_W +: DATA_W]) *
                  $signed(wram_mpe_weight[l*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_d = sum_d + {{(SUM_W-PROD_W){prod_q[l][PROD_W-1]}}, prod_q[l]};
    end
  end

  // NOTE: product/sum registers carry no reset; they are only observed behind s1/s2 valids.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      for (int l = 0; l < LANES; l++) prod_q[l] <= prod_d[l];
    end
    if (s1_vld_q) sum_q <= sum_d;
  end

endmodule
